// File: rtl/temp_ascii_fmt.sv
// Temperature-to-ASCII line formatter: double-dabble the captured magnitude into
// five BCD digits, then stream "+DDD.DD[CR LF]" to the UART over valid/ready.
module temp_ascii_fmt #(
    parameter int APPEND_CRLF = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] temp_data,
    input  logic        sign,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = (APPEND_CRLF != 0) ? 4'd8 : 4'd6;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [15:0] r_bin;
    logic        r_sign;
    logic [19:0] r_bcd;
    logic [19:0] w_bcdAdj;
    logic [3:0]  r_iter;
    logic [3:0]  r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = CONVERT;
                end
            end
            CONVERT: begin
                if (r_iter == 4'd15) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                if (tx_ready && (r_idx == LAST_IDX)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = CONVERT;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble ahead of the shift.
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= 16'd0;
            r_sign <= 1'b0;
            r_bcd  <= 20'd0;
            r_iter <= 4'd0;
            r_idx  <= 4'd0;
        end else if (w_accept) begin
            r_bin  <= temp_data;
            r_sign <= sign;
            r_bcd  <= 20'd0;
            r_iter <= 4'd0;
            r_idx  <= 4'd0;
        end else if (r_state == CONVERT) begin
            r_bcd  <= {w_bcdAdj[18:0], r_bin[15]};
            r_bin  <= {r_bin[14:0], 1'b0};
            r_iter <= r_iter + 4'd1;
        end else if ((r_state == SEND) && tx_ready) begin
            r_idx  <= r_idx + 4'd1;
        end
    end

    assign tx_valid = (r_state == SEND);
    assign busy     = (r_state == CONVERT) || (r_state == SEND);
    assign done     = (r_state == DONE);

    // Digits are always 0..9, so the ASCII code is just the nibble under 0x3_.
    always_comb begin
        tx_data = 8'h00;
        if (tx_valid) begin
            case (r_idx)
                4'd0:    tx_data = r_sign ? 8'h2D : 8'h2B;
                4'd1:    tx_data = {4'h3, r_bcd[19:16]};
                4'd2:    tx_data = {4'h3, r_bcd[15:12]};
                4'd3:    tx_data = {4'h3, r_bcd[11:8]};
                4'd4:    tx_data = 8'h2E;
                4'd5:    tx_data = {4'h3, r_bcd[7:4]};
                4'd6:    tx_data = {4'h3, r_bcd[3:0]};
                4'd7:    tx_data = 8'h0D;
                4'd8:    tx_data = 8'h0A;
                default: tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_ascii_fmt.sv
// Directed bench for temp_ascii_fmt: one DUT with CR/LF, one without, sharing
// data and tx_ready; each test task checks its own expected byte stream.
module tb_temp_ascii_fmt;

    logic        clock;
    logic        rstN;
    logic        start;
    logic        startN;
    logic [15:0] tempData;
    logic        signIn;
    logic        txReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        busy;
    logic        done;
    logic [7:0]  txDataN;
    logic        txValidN;
    logic        busyN;
    logic        doneN;

    int          checkCount;
    int          failCount;
    logic [7:0]  gotBytes [16];
    int          nGot;
    int          latency;
    int          stallErr;
    int          busyErr;
    bit          timedOut;

    temp_ascii_fmt #(.APPEND_CRLF(1)) dut (
        .clk(clock), .rst_n(rstN), .start(start), .temp_data(tempData),
        .sign(signIn), .tx_data(txData), .tx_valid(txValid),
        .tx_ready(txReady), .busy(busy), .done(done)
    );

    temp_ascii_fmt #(.APPEND_CRLF(0)) dutNoCrlf (
        .clk(clock), .rst_n(rstN), .start(startN), .temp_data(tempData),
        .sign(signIn), .tx_data(txDataN), .tx_valid(txValidN),
        .tx_ready(txReady), .busy(busyN), .done(doneN)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Called on a negedge with start already driven; gathers transferred bytes,
    // latency, stall-stability and busy statistics without judging them.
    task automatic collectLine(input bit narrow, input int maxBytes,
                               input int readyPct, input int disturbAt);
        int         cycles;
        bit         v, b, r, prevV, prevR, disturbed, pulsed;
        logic [7:0] d, prevD;
        nGot = 0; latency = -1; stallErr = 0; busyErr = 0; timedOut = 0;
        prevV = 0; prevR = 0; prevD = 8'h00; cycles = 0; disturbed = 0; pulsed = 0;
        while (nGot < maxBytes) begin
            @(negedge clock);
            cycles++;
            if (cycles == 1) begin start = 1'b0; startN = 1'b0; end
            if (pulsed) begin start = 1'b0; pulsed = 0; end
            if (cycles > 500) begin timedOut = 1; break; end
            v = narrow ? txValidN : txValid;
            d = narrow ? txDataN : txData;
            b = narrow ? busyN : busy;
            if (!b) busyErr++;
            if (v && latency < 0) latency = cycles;
            if (prevV && !prevR && (!v || d !== prevD)) stallErr++;
            r = ($urandom_range(99) < readyPct);
            txReady = r;
            if (!disturbed && disturbAt >= 0 && nGot == disturbAt && v) begin
                start = 1'b1; tempData = 16'd1111; signIn = 1'b1;
                disturbed = 1; pulsed = 1;
            end
            if (v && r) begin gotBytes[nGot] = d; nGot++; end
            prevV = v; prevR = r; prevD = d;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; startN = 1'b0; tempData = 16'd0;
        signIn = 1'b0; txReady = 1'b0;
        repeat (3) @(negedge clock);
        checkCount++; if (txValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", txValid); end
        checkCount++; if (txData !== 8'h00) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 00", txData); end
        checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checkCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checkCount++; if (txValidN !== 1'b0) begin failCount++; $display("[TB] FAIL reset_validN: got %b expected 0", txValidN); end
        rstN = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        logic [7:0] exp [9];
        exp = '{8'h2B, 8'h30, 8'h32, 8'h35, 8'h2E, 8'h33, 8'h37, 8'h0D, 8'h0A};
        tempData = 16'd2537; signIn = 1'b0; start = 1'b1;
        collectLine(0, 9, 100, -1);
        checkCount++; if (timedOut) begin failCount++; $display("[TB] FAIL basic_timeout: got %0d bytes expected 9", nGot); end
        checkCount++; if (latency !== 17) begin failCount++; $display("[TB] FAIL basic_latency: got %0d expected 17", latency); end
        checkCount++; if (busyErr !== 0) begin failCount++; $display("[TB] FAIL basic_busy: got %0d low cycles expected 0", busyErr); end
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp[i]) begin failCount++; $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, gotBytes[i], exp[i]); end
        end
        @(negedge clock);
        checkCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL basic_done: got %b expected 1", done); end
        checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL basic_done_busy: got %b expected 0", busy); end
        checkCount++; if (txValid !== 1'b0 || txData !== 8'h00) begin failCount++; $display("[TB] FAIL basic_done_tx: got %b/%h expected 0/00", txValid, txData); end
        @(negedge clock);
        checkCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_max();
        logic [7:0] exp [9];
        exp = '{8'h2D, 8'h36, 8'h35, 8'h35, 8'h2E, 8'h33, 8'h35, 8'h0D, 8'h0A};
        tempData = 16'd65535; signIn = 1'b1; start = 1'b1;
        collectLine(0, 9, 100, -1);
        checkCount++; if (timedOut) begin failCount++; $display("[TB] FAIL max_timeout: got %0d bytes expected 9", nGot); end
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp[i]) begin failCount++; $display("[TB] FAIL max_byte%0d: got %h expected %h", i, gotBytes[i], exp[i]); end
        end
        @(negedge clock);
        checkCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL max_done: got %b expected 1", done); end
        @(negedge clock);
    endtask

    task automatic test_no_crlf();
        logic [7:0] exp [7];
        exp = '{8'h2B, 8'h30, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30};
        tempData = 16'd0; signIn = 1'b0; startN = 1'b1;
        collectLine(1, 7, 100, -1);
        checkCount++; if (timedOut) begin failCount++; $display("[TB] FAIL nocrlf_timeout: got %0d bytes expected 7", nGot); end
        checkCount++; if (latency !== 17) begin failCount++; $display("[TB] FAIL nocrlf_latency: got %0d expected 17", latency); end
        for (int i = 0; i < 7; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp[i]) begin failCount++; $display("[TB] FAIL nocrlf_byte%0d: got %h expected %h", i, gotBytes[i], exp[i]); end
        end
        @(negedge clock);
        checkCount++; if (doneN !== 1'b1) begin failCount++; $display("[TB] FAIL nocrlf_done: got %b expected 1", doneN); end
        checkCount++; if (txValidN !== 1'b0) begin failCount++; $display("[TB] FAIL nocrlf_valid: got %b expected 0", txValidN); end
        checkCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL nocrlf_other_busy: got %b expected 0", busy); end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [9];
        exp = '{8'h2B, 8'h30, 8'h31, 8'h32, 8'h2E, 8'h33, 8'h34, 8'h0D, 8'h0A};
        tempData = 16'd1234; signIn = 1'b0; start = 1'b1;
        collectLine(0, 9, 40, -1);
        checkCount++; if (timedOut) begin failCount++; $display("[TB] FAIL bp_timeout: got %0d bytes expected 9", nGot); end
        checkCount++; if (stallErr !== 0) begin failCount++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stallErr); end
        checkCount++; if (busyErr !== 0) begin failCount++; $display("[TB] FAIL bp_busy: got %0d low cycles expected 0", busyErr); end
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp[i]) begin failCount++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, gotBytes[i], exp[i]); end
        end
        @(negedge clock);
        checkCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL bp_done: got %b expected 1", done); end
        @(negedge clock);
    endtask

    task automatic test_ignore_start();
        logic [7:0] exp [9];
        exp = '{8'h2B, 8'h30, 8'h37, 8'h37, 8'h2E, 8'h37, 8'h37, 8'h0D, 8'h0A};
        tempData = 16'd7777; signIn = 1'b0; start = 1'b1;
        collectLine(0, 9, 100, 3);
        checkCount++; if (timedOut) begin failCount++; $display("[TB] FAIL ignore_timeout: got %0d bytes expected 9", nGot); end
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp[i]) begin failCount++; $display("[TB] FAIL ignore_byte%0d: got %h expected %h", i, gotBytes[i], exp[i]); end
        end
        @(negedge clock);
        checkCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL ignore_done: got %b expected 1", done); end
        @(negedge clock);
        checkCount++; if (busy !== 1'b0 || txValid !== 1'b0) begin failCount++; $display("[TB] FAIL ignore_idle: got busy %b valid %b expected 0/0", busy, txValid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp1 [9];
        logic [7:0] exp2 [9];
        exp1 = '{8'h2B, 8'h30, 8'h30, 8'h30, 8'h2E, 8'h34, 8'h32, 8'h0D, 8'h0A};
        exp2 = '{8'h2D, 8'h30, 8'h30, 8'h31, 8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};
        tempData = 16'd42; signIn = 1'b0; start = 1'b1;
        collectLine(0, 9, 100, -1);
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp1[i]) begin failCount++; $display("[TB] FAIL b2b_first_byte%0d: got %h expected %h", i, gotBytes[i], exp1[i]); end
        end
        @(negedge clock);
        checkCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_done: got %b expected 1", done); end
        tempData = 16'd100; signIn = 1'b1; start = 1'b1;
        collectLine(0, 9, 100, -1);
        checkCount++; if (latency !== 17) begin failCount++; $display("[TB] FAIL b2b_latency: got %0d expected 17", latency); end
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp2[i]) begin failCount++; $display("[TB] FAIL b2b_second_byte%0d: got %h expected %h", i, gotBytes[i], exp2[i]); end
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset_midline();
        logic [7:0] exp [9];
        exp = '{8'h2B, 8'h30, 8'h30, 8'h35, 8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};
        tempData = 16'd9876; signIn = 1'b1; start = 1'b1;
        collectLine(0, 3, 100, -1);
        @(posedge clock);
        #2 rstN = 1'b0;
        #1;
        checkCount++; if (txValid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", txValid); end
        checkCount++; if (txData !== 8'h00) begin failCount++; $display("[TB] FAIL rst_mid_data: got %h expected 00", txData); end
        checkCount++; if (busy !== 1'b0 || done !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_flags: got busy %b done %b expected 0/0", busy, done); end
        @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        tempData = 16'd500; signIn = 1'b0; start = 1'b1;
        collectLine(0, 9, 100, -1);
        checkCount++; if (latency !== 17) begin failCount++; $display("[TB] FAIL rst_mid_latency: got %0d expected 17", latency); end
        for (int i = 0; i < 9; i++) begin
            checkCount++;
            if (gotBytes[i] !== exp[i]) begin failCount++; $display("[TB] FAIL rst_mid_byte%0d: got %h expected %h", i, gotBytes[i], exp[i]); end
        end
        @(negedge clock);
        checkCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_done: got %b expected 1", done); end
        @(negedge clock);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        test_reset();
        test_basic();
        test_max();
        test_no_crlf();
        test_backpressure();
        test_ignore_start();
        test_back_to_back();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/temp_ascii_fmt.md
TEMP_ASCII_FMT -- requirements
Module: temp_ascii_fmt

Purpose: formats the 16-bit temperature magnitude and sign from the DS18B20 driver into an ASCII text line. It feeds the line byte by byte to the UART byte transmitter over a valid/ready handshake.

Interface
REQ-001 Parameter: APPEND_CRLF, default 1, meaning 1 = append CR,LF to each line (9 bytes), 0 = no terminator (7 bytes).
REQ-002 clk  input  1  system clock (12 MHz); all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request to format one sample; single-cycle pulse or level.
REQ-005 temp_data  input  16  unsigned temperature magnitude, units of 0.01 degC.
REQ-006 sign  input  1  1 = negative temperature.
REQ-007 tx_data  output  8  ASCII byte presented to the UART.
REQ-008 tx_valid  output  1  tx_data holds a valid byte.
REQ-009 tx_ready  input  1  UART accepts tx_data this cycle.
REQ-010 busy  output  1  high from the cycle after a start is accepted until the line is complete.
REQ-011 done  output  1  single-cycle pulse on line completion.

Function
REQ-012 States SHALL be IDLE, CONVERT, SEND and DONE; any unencoded state SHALL return to IDLE.
REQ-013 In IDLE, start=1 SHALL be accepted: temp_data and sign are captured, then go to CONVERT; busy=1 from the next cycle.
REQ-014 start SHALL be ignored in CONVERT and SEND; input changes after capture SHALL NOT affect the line.
REQ-015 CONVERT SHALL run a sequential double-dabble conversion: 16 iterations, one per cycle, producing 5 BCD digits D4..D0 in a 20-bit register.
REQ-016 Before each shift, every BCD nibble >= 5 SHALL be incremented by 3.
REQ-017 CONVERT SHALL last exactly 16 cycles; tx_valid SHALL first assert on the 17th cycle after the accept cycle.
REQ-018 Line byte order SHALL be:
- sign char: '-' (0x2D) if sign=1, else '+' (0x2B); a zero magnitude gets no special case;
- D4, D3, D2 as 0x30+digit, with leading zeros kept;
- '.' (0x2E);
- D1, D0;
- if APPEND_CRLF=1: 0x0D, 0x0A.
REQ-019 A byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1; the byte index advances on that edge.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable; tx_valid SHALL NOT drop until transfer.
REQ-021 During SEND, tx_valid SHALL stay 1 continuously; with tx_ready held at 1, one byte transfers per cycle.
REQ-022 After the last byte transfers, the FSM SHALL enter DONE for one cycle:
- done=1, busy=0, tx_valid=0;
- then return to IDLE.
REQ-023 start=1 during the DONE cycle SHALL be accepted exactly as in IDLE.
REQ-024 The maximum input 65535 SHALL render as 655.35; no overflow or clamp is needed.
REQ-025 tx_data SHALL be 0x00 whenever tx_valid=0.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force the following, in any state including mid-CONVERT or mid-SEND:
- state=IDLE;
- tx_valid=0, tx_data=0x00, busy=0, done=0;
- BCD register, byte index and captured inputs cleared.
REQ-027 After rst_n deasserts, the first start SHALL produce a complete, correct line; no partial line from before reset SHALL resume.

Verification
REQ-028 temp_data=2537, sign=0, tx_ready=1 -> bytes 2B 30 32 35 2E 33 37 0D 0A on consecutive cycles; first valid 17 cycles after accept; done one cycle after 0A.
REQ-029 temp_data=65535, sign=1 -> "-655.35\r\n" (2D 36 35 35 2E 33 35 0D 0A).
REQ-030 APPEND_CRLF=0, temp_data=0, sign=0 -> exactly 7 bytes "+000.00"; done after the 7th byte.
REQ-031 Random tx_ready backpressure on temp_data=1234 -> "+012.34\r\n" with no dropped or duplicated bytes; tx_data stable while stalled.
REQ-032 Pulse start again during SEND and change temp_data mid-line -> the second start is ignored and the line reflects the first capture only.
REQ-033 Assert rst_n=0 after the 3rd byte -> tx_valid=0 immediately; after release, start with 500 -> full "+005.00\r\n".
